// File: rtl/t13_evt_pkg.sv
// rtl/t13_evt_pkg.sv - shared sizes, output FSM states and index helpers for the event encoder
package t13_evt_pkg;

    localparam int N_EVT = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic logic [N_EVT-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_EVT-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/t13_rr_pick.sv
// rtl/t13_rr_pick.sv - combinational search for the first set request at or after a start index, wrapping
module t13_rr_pick
    import t13_evt_pkg::*;
(
    input  logic [N_EVT-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from far to near so the nearest hit is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_EVT - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/t13_event_encoder.sv
// rtl/t13_event_encoder.sv - pending-event register with round-robin or fixed-priority index presentation
module t13_event_encoder
    import t13_evt_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_EVT-1:0] evt_in,
    input  logic             clr_all,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_EVT-1:0] pending,
    output logic             overflow
);

    state_e           state_q, state_d;
    logic [N_EVT-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    logic             hs;
    logic [N_EVT-1:0] clr_mask;
    logic [N_EVT-1:0] remain;
    logic [IDX_W-1:0] pick_start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign hs       = (state_q == PRESENT) && out_ready;
    assign clr_mask = hs ? idx_onehot(out_idx_q) : '0;
    assign remain   = pending_q & ~clr_mask;

    // On a handshake the accepted index becomes the new last grant, so search from just past it.
    always_comb begin
        pick_start = '0;
        if (RR_EN) begin
            pick_start = hs ? (out_idx_q + 1'b1) : (last_grant_q + 1'b1);
        end
    end

    t13_rr_pick u_pick (
        .req   (remain),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        out_idx_d    = out_idx_q;
        last_grant_d = last_grant_q;
        pending_d    = remain | evt_in;
        overflow_d   = overflow_q | (|(evt_in & remain));

        if (hs) begin
            last_grant_d = out_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d   = PRESENT;
                    out_idx_d = pick_idx;
                end
            end
            PRESENT: begin
                if (hs) begin
                    if (pick_found) begin
                        out_idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_all) begin
            state_d      = IDLE;
            pending_d    = '0;
            overflow_d   = 1'b0;
            out_idx_d    = '0;
            last_grant_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
            out_idx_q    <= '0;
            last_grant_q <= '1;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            out_idx_q    <= out_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
